rtc_read_cycle: RTL and testbench

Bus-cycle generator for reading one register of the external multiplexed-address/data RTC chip. It runs the same strobe protocol as the write-cycle FSM, but in the opposite direction. It drives the address phase (AD, CS, WR strobes with the address on the bus), then runs a data phase with RD low and captures the byte the chip returns. It sits between the RTC controller sequencer (start/addr/done handshake) and the bidirectional pad wrapper (bus_oe, addr_out, data_in).

---
 rtl/rtc_bus_pkg.sv | 57 +++++
 rtl/rtc_phase_timer.sv | 37 +++
 rtl/rtc_read_cycle.sv | 142 ++++++++++++++
 tb/tb_rtc_read_cycle.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus cycle generators.
// Contents:
//   rtc_state_e   - bus-cycle state encoding, shared with the write FSM
//   DEF_T_*       - default cycle counts for each protocol phase
//   rtc_strobes_t - active-low strobe bundle {ad_n, cs_n, wr_n, rd_n}
//   STROBE_IDLE   - all strobes deasserted
//   strobes_for / bus_oe_for - per-state output decode (Moore)
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_AD,
    ST_A_CS,
    ST_A_WR,
    ST_A_HOLD,
    ST_A_REL,
    ST_D_CS,
    ST_D_RD,
    ST_D_END
  } rtc_state_e;

  localparam int DEF_T_STEP = 10;
  localparam int DEF_T_PW   = 50;
  localparam int DEF_T_ACC  = 40;
  localparam int DEF_T_REC  = 40;

  typedef struct packed {
    logic ad_n;
    logic cs_n;
    logic wr_n;
    logic rd_n;
  } rtc_strobes_t;

  localparam rtc_strobes_t STROBE_IDLE = rtc_strobes_t'(4'b1111);

  function automatic rtc_strobes_t strobes_for(input rtc_state_e st);
    rtc_strobes_t s;
    s = STROBE_IDLE;
    case (st)
      ST_A_AD:   s.ad_n = 1'b0;
      ST_A_CS:   begin s.ad_n = 1'b0; s.cs_n = 1'b0; end
      ST_A_WR:   begin s.ad_n = 1'b0; s.cs_n = 1'b0; s.wr_n = 1'b0; end
      ST_A_HOLD: s.ad_n = 1'b0;
      ST_D_CS:   s.cs_n = 1'b0;
      ST_D_RD:   begin s.cs_n = 1'b0; s.rd_n = 1'b0; end
      default:   s = STROBE_IDLE;
    endcase
    return s;
  endfunction

  // The address is driven only while WR is low and through the hold step,
  // so the pad is already released a full step before RD can fall.
  function automatic logic bus_oe_for(input rtc_state_e st);
    return (st == ST_A_WR) || (st == ST_A_HOLD);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer for the RTC bus FSMs.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   clear      - zero the counter on the next edge (state entry)
//   limit      - terminal count, i.e. phase duration minus one
//   expire     - high while the counter equals limit (last cycle of phase)
module rtc_phase_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == limit);

endmodule

// File: rtl/rtc_read_cycle.sv
// Read bus-cycle generator for the multiplexed address/data RTC chip.
// Drives the address phase (AD, CS, WR with address on the bus), turns the
// bus around, then runs a data phase with RD low and captures the returned
// byte on the last RD-low cycle.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, addr         - request from the sequencer (accepted only in idle)
//   data_in             - bus value from the pad wrapper
//   ad_n/cs_n/wr_n/rd_n - active-low bus strobes (decoded from state only)
//   bus_oe, addr_out    - pad drive enable and latched address
//   data_out            - captured read byte, held until the next capture
//   busy, done          - cycle in progress / one-cycle completion pulse
module rtc_read_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_STEP = DEF_T_STEP,
  parameter int T_PW   = DEF_T_PW,
  parameter int T_ACC  = DEF_T_ACC,
  parameter int T_REC  = DEF_T_REC,
  parameter int CNT_W  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic       ad_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       bus_oe,
  output logic [7:0] addr_out,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(T_STEP - 1);
  localparam logic [CNT_W-1:0] LAST_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LAST_ACC  = CNT_W'(T_ACC - 1);
  localparam logic [CNT_W-1:0] LAST_REC  = CNT_W'(T_REC - 1);

  rtc_state_e       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;

  logic             tmr_clear;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_expire;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    tmr_limit = '0;
    // Every phase exit is a state entry, so the counter restarts from zero.
    tmr_clear = tmr_expire;

    case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (start) begin
          state_d = ST_A_AD;
          addr_d  = addr;
        end
      end
      ST_A_AD: begin
        tmr_limit = LAST_STEP;
        if (tmr_expire) state_d = ST_A_CS;
      end
      ST_A_CS: begin
        tmr_limit = LAST_STEP;
        if (tmr_expire) state_d = ST_A_WR;
      end
      ST_A_WR: begin
        tmr_limit = LAST_PW;
        if (tmr_expire) state_d = ST_A_HOLD;
      end
      ST_A_HOLD: begin
        tmr_limit = LAST_STEP;
        if (tmr_expire) state_d = ST_A_REL;
      end
      ST_A_REL: begin
        tmr_limit = LAST_STEP;
        if (tmr_expire) state_d = ST_D_CS;
      end
      ST_D_CS: begin
        tmr_limit = LAST_STEP;
        if (tmr_expire) state_d = ST_D_RD;
      end
      ST_D_RD: begin
        tmr_limit = LAST_ACC;
        if (tmr_expire) begin
          state_d = ST_D_END;
          data_d  = data_in;
        end
      end
      ST_D_END: begin
        tmr_limit = LAST_REC;
        if (tmr_expire) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign {ad_n, cs_n, wr_n, rd_n} = strobes_for(state_q);
  assign bus_oe   = bus_oe_for(state_q);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign addr_out = addr_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_rtc_read_cycle.sv
module tb_rtc_read_cycle;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start_m;
  logic [7:0] addr, data_in;

  logic       ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done;
  logic [7:0] addr_out, data_out;
  logic       ad_n_m, cs_n_m, wr_n_m, rd_n_m, bus_oe_m, busy_m, done_m;
  logic [7:0] addr_out_m, data_out_m;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t sb_m[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int done_base;

  always #5 clk = ~clk;

  rtc_read_cycle dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .data_in(data_in),
    .ad_n(ad_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .bus_oe(bus_oe),
    .addr_out(addr_out), .data_out(data_out), .busy(busy), .done(done)
  );

  rtc_read_cycle #(.T_STEP(1), .T_PW(1), .T_ACC(1), .T_REC(1)) dut_m (
    .clk(clk), .reset(reset), .start(start_m), .addr(addr), .data_in(data_in),
    .ad_n(ad_n_m), .cs_n(cs_n_m), .wr_n(wr_n_m), .rd_n(rd_n_m), .bus_oe(bus_oe_m),
    .addr_out(addr_out_m), .data_out(data_out_m), .busy(busy_m), .done(done_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done} at offset o after
  // the start sample edge, for phase lengths s/p/a/r.
  function automatic logic [6:0] exp_vec(input int o, input int s, input int p,
                                         input int a, input int r);
    int t_cs, t_wr, t_hold, t_rel, t_dcs, t_rd, t_end, t_done;
    logic [6:0] v;
    t_cs   = s;
    t_wr   = 2 * s;
    t_hold = 2 * s + p;
    t_rel  = t_hold + s;
    t_dcs  = t_rel + s;
    t_rd   = t_dcs + s;
    t_end  = t_rd + a;
    t_done = t_end + r;
    v[6] = !(o < t_rel);
    v[5] = !((o >= t_cs && o < t_hold) || (o >= t_dcs && o < t_end));
    v[4] = !(o >= t_wr && o < t_hold);
    v[3] = !(o >= t_rd && o < t_end);
    v[2] = (o >= t_wr && o < t_rel);
    v[1] = (o < t_done);
    v[0] = (o == t_done);
    return v;
  endfunction

  task automatic chk_vec(input int o);
    chk($sformatf("vec@%0d", o), {ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done},
        exp_vec(o, 10, 50, 40, 40));
  endtask

  task automatic chk_vec_m(input int o);
    chk($sformatf("vec_min@%0d", o),
        {ad_n_m, cs_n_m, wr_n_m, rd_n_m, bus_oe_m, busy_m, done_m},
        exp_vec(o, 1, 1, 1, 1));
  endtask

  // Advance one cycle, observe 1 time unit after the edge, service the
  // scoreboards and the bus_oe/rd_n exclusion check.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    chk("oe_rd_excl", {31'd0, bus_oe & ~rd_n}, 32'd0);
    chk("oe_rd_excl_min", {31'd0, bus_oe_m & ~rd_n_m}, 32'd0);
    if (done) begin
      done_cnt++;
      chk("done_has_request", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", {24'd0, data_out}, {24'd0, e.data});
        chk("sb_addr", {24'd0, addr_out}, {24'd0, e.addr});
      end
    end
    if (done_m) begin
      chk("done_min_has_request", {31'd0, sb_m.size() != 0}, 32'd1);
      if (sb_m.size() != 0) begin
        e = sb_m.pop_front();
        chk("sb_min_data", {24'd0, data_out_m}, {24'd0, e.data});
        chk("sb_min_addr", {24'd0, addr_out_m}, {24'd0, e.addr});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start_m = 1'b0;
    addr    = 8'h00;
    data_in = 8'h00;

    // Reset state
    step(); step(); step();
    chk("reset_vec", {ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done}, 7'b1111000);
    chk("reset_addr_out", {24'd0, addr_out}, 32'd0);
    chk("reset_data_out", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    step(); step();
    chk("idle_vec", {ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done}, 7'b1111000);

    // Read 1: addr 0x0A, data 0x5C, ignored start at cycle 50
    addr = 8'h0A; data_in = 8'h5C;
    sb.push_back('{addr: 8'h0A, data: 8'h5C});
    done_base = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int o = 0; o <= 180; o++) begin
      chk_vec(o);
      if (o == 60) chk("addr_held_while_busy", {24'd0, addr_out}, 32'h0A);
      if (o == 50) begin
        start = 1'b1;
        addr  = 8'h33;
      end else begin
        start = 1'b0;
      end
      if (o < 180) step();
    end
    chk("read1_data_out", {24'd0, data_out}, 32'h5C);
    chk("one_done_only", done_cnt - done_base, 1);

    // Read 2: back-to-back start in the done cycle; sample-edge data timing
    addr = 8'h44; data_in = 8'h33;
    sb.push_back('{addr: 8'h44, data: 8'h11});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_addr_latched", {24'd0, addr_out}, 32'h44);
    for (int o = 0; o <= 180; o++) begin
      chk_vec(o);
      if (o == 139) data_in = 8'h11;
      if (o == 140) begin
        data_in = 8'h22;
        chk("sample_edge_data", {24'd0, data_out}, 32'h11);
      end
      if (o == 150) chk("late_change_ignored", {24'd0, data_out}, 32'h11);
      if (o < 180) step();
    end

    // Read 3: asynchronous reset during D_RD, then a full read
    step(); step(); step();
    addr = 8'h5A; data_in = 8'h77;
    sb.push_back('{addr: 8'h5A, data: 8'h77});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int o = 0; o <= 110; o++) begin
      chk_vec(o);
      if (o < 110) step();
    end
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_vec", {ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done}, 7'b1111000);
    chk("async_reset_addr", {24'd0, addr_out}, 32'd0);
    chk("async_reset_data", {24'd0, data_out}, 32'd0);
    sb.delete();
    done_base = done_cnt;
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("no_done_after_reset", done_cnt - done_base, 0);

    addr = 8'h66; data_in = 8'h77;
    sb.push_back('{addr: 8'h66, data: 8'h77});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int o = 0; o <= 180; o++) begin
      chk_vec(o);
      if (o < 180) step();
    end
    chk("read_after_reset_data", {24'd0, data_out}, 32'h77);

    // Minimum configuration: all phases one cycle
    step(); step();
    addr = 8'hFF; data_in = 8'hA5;
    sb_m.push_back('{addr: 8'hFF, data: 8'hA5});
    start_m = 1'b1;
    step();
    start_m = 1'b0;
    for (int o = 0; o <= 8; o++) begin
      chk_vec_m(o);
      if (o < 8) step();
    end
    chk("min_data_out", {24'd0, data_out_m}, 32'hA5);
    step(); step();
    chk("sb_drained", sb.size() + sb_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
